// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU and its memory-side responder:
// responder state encoding, word/byte geometry and the CPU memory opcodes.
package cpu_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;
   localparam int unsigned LAT_W      = 4;

   // Responder handshake states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;

   // Major opcodes the CPU FSM issues to the memory side
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x DATA_W word storage: synchronous byte-enable write, registered read.
// Contents are deliberately not reset.
module mem_word_array
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   idx,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/BYTE_W-1:0]   be,
   output logic [DATA_W-1:0]          rdata
);

   localparam int unsigned BE_W = DATA_W / BYTE_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane write and registered read on the same port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
               mem[idx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
         end
      end
      if (rd_en) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multi-cycle CPU: accepts one request, waits
// LATENCY cycles, performs the word access and holds one response until taken.
// Optional feature macro: ADDR_CHECK_EN (flags accesses above the storage range).
module cpu_mem_responder
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   input  logic [DATA_W/BYTE_W-1:0]   req_be,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       resp_err
);

   localparam int unsigned BE_W  = DATA_W / BYTE_W;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = LAT_W;

   mem_state_t        state;
   mem_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;

   logic              lat_we;
   logic [IDX_W-1:0]  lat_idx;
   logic [DATA_W-1:0] lat_wdata;
   logic [BE_W-1:0]   lat_be;
   logic              lat_err;

   logic              accept;
   logic              access;
   logic              addr_err;
   logic              wr_en;
   logic              rd_en;
   logic              rd_hold;
   logic [DATA_W-1:0] arr_rdata;
   logic              unused_addr;

`ifdef ADDR_CHECK_EN
   assign addr_err    = |req_addr[ADDR_W-1:IDX_W+2];
   assign unused_addr = ^req_addr[1:0];
`else
   // Upper bits ignored: addresses alias modulo DEPTH words
   assign addr_err    = 1'b0;
   assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (req_valid)         state_nxt = ST_WAIT;
         ST_WAIT: if (cnt == CNT_W'(0))  state_nxt = ST_RESP;
         ST_RESP: if (resp_ready)        state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded handshakes and access strobes
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      access     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
         end
         ST_WAIT: access = (cnt == CNT_W'(0));
         ST_RESP: resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request capture, wait-state counter and response status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         lat_err   <= 1'b0;
         rd_hold   <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= CNT_W'(LATENCY);
            lat_we    <= req_we;
            lat_idx   <= req_addr[IDX_W+1:2];
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_err   <= addr_err;
         end else if (state == ST_WAIT && cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (access) begin
            rd_hold  <= !lat_we && !lat_err;
            resp_err <= lat_err;
         end else if (state == ST_RESP && resp_ready) begin
            resp_err <= 1'b0;
         end
      end
   end

   assign wr_en = access && lat_we && !lat_err;
   assign rd_en = access && !lat_we && !lat_err;

   // Read data is held in the array's output register; writes, errors and
   // reset present zero by gating it with the registered rd_hold flag.
   assign resp_rdata = rd_hold ? arr_rdata : '0;

   mem_word_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .idx   (lat_idx),
      .wdata (lat_wdata),
      .be    (lat_be),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: the driver queues accepted requests,
// the monitor computes expected responses from a word-array model on arrival.
module tb_cpu_mem_responder;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned LAT    = 2;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
`ifdef ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int unsigned acc;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned drv_tmo = 0;
   int unsigned drain_tmo = 0;
   int unsigned bp_until = 0;
   bit          rr_mode = 1'b0;
   req_t        q[$];
   logic [31:0] mem_m [DEPTH];

   cpu_mem_responder #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // Reference behaviour of one access: word index from the byte address,
   // optional range error, byte-lane merge on stores, full word on loads.
   function automatic void model_access(input req_t r, output logic [31:0] rd, output logic er);
      int unsigned idx;
      idx = int'(r.addr >> 2) % DEPTH;
      er  = CHK && ((r.addr >> (IDX_W + 2)) != 0);
      rd  = '0;
      if (!er) begin
         if (r.we) begin
            for (int b = 0; b < 4; b++)
               if (r.be[b]) mem_m[idx][b*8 +: 8] = r.wdata[b*8 +: 8];
         end else begin
            rd = mem_m[idx];
         end
      end
   endfunction

   // Present a request and hold it until the responder takes it
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
      req_t r;
      int unsigned guard;
      guard     = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         guard++;
         if (guard > 500) begin
            drv_tmo++;
            req_valid = 1'b0;
            return;
         end
      end
      r.we = we; r.addr = addr; r.wdata = wdata; r.be = be; r.acc = cyc + 1;
      q.push_back(r);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
   endtask

   // Response-side acceptance: forced low windows, else always or random
   initial begin
      resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (cyc < bp_until)  resp_ready = 1'b0;
         else if (rr_mode)    resp_ready = ($urandom_range(0, 3) != 0);
         else                 resp_ready = 1'b1;
      end
   end

   // Monitor / scoreboard
   initial begin : monitor
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_ready;
      logic        held;
      int unsigned tmo_seen;
      int unsigned drain_seen;
      exp_rdata = '0; exp_err = 1'b0; held = 1'b0; tmo_seen = 0; drain_seen = 0;
      forever begin
         @(negedge clk);
         if (drv_tmo != tmo_seen) begin
            tmo_seen = drv_tmo;
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready never rose, got 0 expected 1 at cycle %0d", cyc);
         end
         if (drain_tmo != drain_seen) begin
            drain_seen = drain_tmo;
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
         end
         if (!rst_n) begin
            chk("rst_req_ready",  32'(req_ready),  32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_rdata", resp_rdata,      32'd0);
            chk("rst_resp_err",   32'(resp_err),   32'd0);
            q.delete();
            held = 1'b0;
         end else begin
            exp_ready = 1'b1;
            foreach (q[i]) if (q[i].acc <= cyc) exp_ready = 1'b0;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (resp_valid) begin
               if (q.size() == 0 || q[0].acc > cyc) begin
                  n_cmp++; n_bad++;
                  $display("FAIL spurious_resp: resp_valid 1 expected 0 at cycle %0d", cyc);
               end else begin
                  if (!held) begin
                     chk("latency", cyc - q[0].acc, LAT + 1);
                     model_access(q[0], exp_rdata, exp_err);
                  end
                  chk("resp_rdata", resp_rdata, exp_rdata);
                  chk("resp_err", 32'(resp_err), 32'(exp_err));
                  if (resp_ready) void'(q.pop_front());
               end
            end
            held = resp_valid && !resp_ready;
         end
      end
   end

   // Stimulus
   initial begin : stim
      logic [31:0] a;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fill every word so all later reads are predictable
      rr_mode = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++)
         do_req(1'b1, 32'(i) << 2, $urandom, 4'hF);

      // word store/load, byte lane, empty byte enable, aliasing/range
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      do_req(1'b1, 32'h10, 32'h000000AA, 4'h1);
      do_req(1'b0, 32'h10, 32'h0, 4'hF);
      do_req(1'b1, 32'h10, 32'h5555_1234, 4'h0);
      do_req(1'b0, 32'h13, 32'h0, 4'h0);
      do_req(1'b0, 32'h400, 32'h0, 4'h0);
      do_req(1'b1, 32'h404, 32'h0BAD_F00D, 4'hF);
      do_req(1'b0, 32'h4, 32'h0, 4'h0);

      // backpressure with the next request already waiting
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      bp_until = cyc + LAT + 7;
      do_req(1'b0, 32'h14, 32'h0, 4'h0);
      do_req(1'b0, 32'h18, 32'h0, 4'h0);

      // reset while a store is still waiting: it must be dropped
      do_req(1'b1, 32'h10, 32'h1234_5678, 4'hF);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_req(1'b0, 32'h10, 32'h0, 4'h0);

      // randomized traffic with random response backpressure
      rr_mode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
         do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end

      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) drain_tmo++;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU FSM.
- The CPU issues an instruction fetch during IFetch and a load/store during Memory; this block accepts each request, inserts configurable wait states, performs the access on internal word storage and returns one response.
- Single outstanding request, valid/ready handshakes on both the request and response channels.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 256: storage size in words; power of 2.
- LATENCY, 2: wait-state cycles, range 0..15.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  1: CPU request present.
- req_ready  out  1: responder can accept a request.
- req_we  in  1: 1 = store, 0 = load/fetch.
- req_addr  in  ADDR_W: byte address.
- req_wdata  in  DATA_W: store data.
- req_be  in  DATA_W/8: store byte enables.
- resp_valid  out  1: response present.
- resp_ready  in  1: CPU accepts the response.
- resp_rdata  out  DATA_W: load data.
- resp_err  out  1: address error (only with ADDR_CHECK_EN).

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (async, on rst_n low): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Storage contents are not reset.
  - Reset mid-operation drops the pending request. No write occurs unless the access edge has already passed.
- req_ready is decoded from state: 1 only in IDLE.
- IDLE:
  - On an edge with req_valid=1, latch we/addr/wdata/be, load counter=LATENCY, go to WAIT.
- WAIT:
  - counter!=0: decrement.
  - counter==0, this is the access edge:
    - Read: resp_rdata = mem[index].
    - Write: update each byte lane whose be bit is set; resp_rdata=0.
    - Set resp_valid=1 and go to RESP.
- Latency: resp_valid rises LATENCY+1 cycles after the accept edge (3 at default).
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable while resp_ready=0.
  - On the edge with resp_ready=1: resp_valid=0, go to IDLE.
- Simultaneous events: a req_valid in the same cycle as the response handshake is not accepted, because req_ready=0. The earliest next accept is the following cycle. Minimum request spacing is LATENCY+3 cycles.
- Index: req_addr[log2(DEPTH)+1:2]. Low two address bits are ignored; alignment is the CPU's responsibility.
- Reads always return the full word; be is ignored on reads.
- A write with be=0 leaves storage unchanged and still responds normally.
- req_* inputs are sampled only at the accept edge; changes afterwards have no effect.

Optional Feature:
- Macro: ADDR_CHECK_EN.
- Defined:
  - An address with any nonzero bit above the index range is out of range.
  - Out-of-range access: no write, resp_rdata=0, resp_err=1, same latency.
  - resp_err clears on the response handshake.
- Undefined: upper address bits are ignored, so addresses alias modulo DEPTH words, and resp_err is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - State encoding for IDLE/WAIT/RESP.
  - Word/byte width constants.
  - Opcode constants shared with the CPU FSM.
- Sub-module mem_word_array: DEPTH x DATA_W storage with synchronous byte-enable write and registered read. No reset.
- The responder FSM instantiates mem_word_array.

Test Plan:
1. Reset: assert rst_n low during WAIT -> req_ready=1 and resp_valid=0 immediately; a subsequent read of that address shows the old contents.
2. Word store/load: store 0xDEADBEEF to 0x10 with be=0xF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_valid exactly 3 cycles after accept (LATENCY=2).
3. Byte lanes: store 0x000000AA with be=0x1 over 0xDEADBEEF -> load returns 0xDEADBEAA; a store with be=0x0 leaves 0xDEADBEAA.
4. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid/resp_rdata stable, req_ready=0, no second accept until the cycle after the handshake.
5. Address range, DEPTH=256, load 0x400 -> with ADDR_CHECK_EN: resp_err=1, resp_rdata=0; without: returns the word at 0x000.
6. LATENCY=0 back-to-back loads with resp_ready=1 -> resp_valid 1 cycle after each accept, accepts spaced exactly 3 cycles apart.
